// File: rtl/riscv_wb_arbiter_pkg.sv
// riscv_wb_arbiter_pkg: shared widths and load-format codes for the writeback arbiter.
//   WB_DW     default datapath width
//   ZERO_REG  x0, never written to the register file
//   load_f3_e load funct3 encodings; f3_is_* classify a stored funct3 at FIFO pop
package riscv_wb_arbiter_pkg;
    localparam int WB_DW = 32;
    localparam logic [4:0] ZERO_REG = 5'd0;
    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;
    function automatic logic f3_is_byte(input logic [2:0] f3);
        return f3 == F3_LB || f3 == F3_LBU;
    endfunction
    function automatic logic f3_is_half(input logic [2:0] f3);
        return f3 == F3_LH || f3 == F3_LHU;
    endfunction
    function automatic logic f3_is_signed(input logic [2:0] f3);
        return f3 == F3_LB || f3 == F3_LH;
    endfunction
endpackage

// File: rtl/riscv_wb_arbiter_if.sv
// riscv_wb_arbiter_if: bundle of pipeline, long-latency, hazard-query and regfile-write signals.
//   slave  modport: the arbiter (consumes pipe_*/ll_*/query_index_i, drives the rest)
//   master modport: upstream pipeline / regfile side
interface riscv_wb_arbiter_if
    import riscv_wb_arbiter_pkg::*;
#(
    parameter int DW = WB_DW
) ();
    logic          pipe_valid_i;
    logic [4:0]    pipe_index_i;
    logic [DW-1:0] pipe_data_i;
    logic          pipe_stall_o;
    logic          ll_valid_i;
    logic          ll_ready_o;
    logic [4:0]    ll_index_i;
    logic [DW-1:0] ll_data_i;
    logic [2:0]    ll_funct3_i;
    logic [1:0]    ll_addr_lo_i;
    logic [4:0]    query_index_i;
    logic          query_hit_o;
    logic [4:0]    WrIndex_o;
    logic [DW-1:0] Data_o;
    logic          Wr_o;
    modport slave (
        input  pipe_valid_i, pipe_index_i, pipe_data_i,
        input  ll_valid_i, ll_index_i, ll_data_i, ll_funct3_i, ll_addr_lo_i,
        input  query_index_i,
        output pipe_stall_o, ll_ready_o, query_hit_o,
        output WrIndex_o, Data_o, Wr_o
    );
    modport master (
        output pipe_valid_i, pipe_index_i, pipe_data_i,
        output ll_valid_i, ll_index_i, ll_data_i, ll_funct3_i, ll_addr_lo_i,
        output query_index_i,
        input  pipe_stall_o, ll_ready_o, query_hit_o,
        input  WrIndex_o, Data_o, Wr_o
    );
endinterface

// File: rtl/riscv_wb_arbiter_fifo.sv
// riscv_wb_arbiter_fifo: long-latency result FIFO storing {index, funct3, addr_lo, data}.
//   push/pop      enqueue at write pointer / dequeue head (caller guarantees !full / !empty)
//   full/empty    occupancy flags from registered per-entry valid bits
//   head_*        fields of the oldest entry
//   ent_valid/ent_index  per-slot valid and destination, for the hazard query
module riscv_wb_arbiter_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push,
    input  logic [4:0]            push_index,
    input  logic [2:0]            push_funct3,
    input  logic [1:0]            push_addr_lo,
    input  logic [DW-1:0]         push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [4:0]            head_index,
    output logic [2:0]            head_funct3,
    output logic [1:0]            head_addr_lo,
    output logic [DW-1:0]         head_data,
    output logic [DEPTH-1:0]      ent_valid,
    output logic [DEPTH-1:0][4:0] ent_index
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] vld_n;
    logic [4:0]       idx_mem  [DEPTH];
    logic [2:0]       f3_mem   [DEPTH];
    logic [1:0]       lo_mem   [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    // Per-slot valid bits make full/empty trivial; a same-cycle push and pop
    // touch different slots because push is blocked when full.
    always_comb begin
        vld_n = vld;
        if (pop) vld_n[rd_ptr] = 1'b0;
        if (push) vld_n[wr_ptr] = 1'b1;
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            vld    <= vld_n;
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push) begin
            idx_mem[wr_ptr]  <= push_index;
            f3_mem[wr_ptr]   <= push_funct3;
            lo_mem[wr_ptr]   <= push_addr_lo;
            data_mem[wr_ptr] <= push_data;
        end
    end
    always_comb begin
        for (int i = 0; i < DEPTH; i++) ent_index[i] = idx_mem[i];
    end
    assign full         = &vld;
    assign empty        = ~|vld;
    assign ent_valid    = vld;
    assign head_index   = idx_mem[rd_ptr];
    assign head_funct3  = f3_mem[rd_ptr];
    assign head_addr_lo = lo_mem[rd_ptr];
    assign head_data    = data_mem[rd_ptr];
endmodule

// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter: writeback stage merging in-order pipeline results and buffered
// long-latency results into the single register-file write port.
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-low reset
//   bus    riscv_wb_arbiter_if.slave: pipe_* in / pipe_stall_o out, ll_* in / ll_ready_o out,
//          query_index_i in / query_hit_o out, registered WrIndex_o/Data_o/Wr_o out
// Optional macro RISCV_WB_FAIR_EN: after FAIR_LIMIT consecutive lost cycles the FIFO head is
// forced through and the pipeline is stalled for that cycle. Without it the pipeline always wins.
module riscv_wb_arbiter
    import riscv_wb_arbiter_pkg::*;
#(
    parameter int DW         = WB_DW,
    parameter int FIFO_DEPTH = 2,
    parameter int FAIR_LIMIT = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    riscv_wb_arbiter_if.slave      bus
);
    logic                       full;
    logic                       empty;
    logic [4:0]                 head_index;
    logic [2:0]                 head_funct3;
    logic [1:0]                 head_addr_lo;
    logic [DW-1:0]              head_data;
    logic [FIFO_DEPTH-1:0]      ent_valid;
    logic [FIFO_DEPTH-1:0][4:0] ent_index;
    logic                       push;
    logic                       pop;
    logic                       stall;
    logic                       pipe_win;
    logic                       hit;
    logic [4:0]                 win_index;
    logic [DW-1:0]              win_data;
    logic [7:0]                 ld_byte;
    logic [15:0]                ld_half;
    logic                       sgn;
    logic [DW-1:0]              ll_aligned;

    riscv_wb_arbiter_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push         (push),
        .push_index   (bus.ll_index_i),
        .push_funct3  (bus.ll_funct3_i),
        .push_addr_lo (bus.ll_addr_lo_i),
        .push_data    (bus.ll_data_i),
        .pop          (pop),
        .full         (full),
        .empty        (empty),
        .head_index   (head_index),
        .head_funct3  (head_funct3),
        .head_addr_lo (head_addr_lo),
        .head_data    (head_data),
        .ent_valid    (ent_valid),
        .ent_index    (ent_index)
    );

    assign push            = bus.ll_valid_i & ~full;
    assign bus.ll_ready_o  = ~full;
    assign bus.pipe_stall_o = stall;
    assign pipe_win        = bus.pipe_valid_i & ~stall;
    assign pop             = ~pipe_win & ~empty;

`ifdef RISCV_WB_FAIR_EN
    localparam int CW = $clog2(FAIR_LIMIT + 1);
    logic [CW-1:0] fair_cnt;
    assign stall = ~empty & (fair_cnt == CW'(FAIR_LIMIT));
    // Counts cycles the head sits behind the pipeline; any pop or an empty FIFO restarts it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) fair_cnt <= '0;
        else        fair_cnt <= (pop | empty) ? '0 : fair_cnt + 1'b1;
    end
`else
    localparam int unused_fair_limit = FAIR_LIMIT;
    assign stall = 1'b0;
`endif

    // Load alignment happens on the way out of the FIFO so the stored data stays raw.
    always_comb begin
        ld_byte    = 8'(head_data >> {head_addr_lo, 3'b000});
        ld_half    = head_addr_lo[1] ? head_data[31:16] : head_data[15:0];
        sgn        = f3_is_signed(head_funct3);
        ll_aligned = f3_is_byte(head_funct3) ? {{(DW-8){sgn & ld_byte[7]}}, ld_byte} :
                     f3_is_half(head_funct3) ? {{(DW-16){sgn & ld_half[15]}}, ld_half} :
                     head_data;
    end

    // The head stays in ent_valid during its pop cycle, so that case is covered too.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) hit = hit | (ent_valid[i] & (ent_index[i] == bus.query_index_i));
    end
    assign bus.query_hit_o = hit & (bus.query_index_i != ZERO_REG);

    assign win_index = pipe_win ? bus.pipe_index_i : head_index;
    assign win_data  = pipe_win ? bus.pipe_data_i : ll_aligned;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bus.Wr_o      <= 1'b0;
            bus.WrIndex_o <= '0;
            bus.Data_o    <= '0;
        end else begin
            bus.Wr_o <= (pipe_win | pop) & (win_index != ZERO_REG);
            if (pipe_win | pop) begin
                bus.WrIndex_o <= win_index;
                bus.Data_o    <= win_data;
            end
        end
    end
endmodule
